// File: rtl/branch_predictor_btb_pkg.sv
`default_nettype none
// ============================================================================
// Module : branch_predictor_btb_pkg
// Brief  : Shared constants and helpers for the BTB (counter encodings,
//          PC index/tag extraction, sequential PC increment).
// Rev    : 1.0
// ============================================================================
package branch_predictor_btb_pkg;

    localparam int unsigned PC_INC = 4;

    // Weakly-not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
    function automatic logic [31:0] cnt_weak_nt(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Weakly-taken: MSB set, all lower bits clear.
    function automatic logic [31:0] cnt_weak_t(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    // Word-aligned index: pc[idx_w+1:2].
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Tag: every PC bit above the index field.
    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage : branch_predictor_btb_pkg
`default_nettype wire

// File: rtl/branch_predictor_btb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up/down counter with synchronous load, async reset.
// Rev    : 1.0
// ============================================================================
module sat_counter #(
    parameter int              WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Load wins over counting; counting never wraps in either direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && (r_count != {WIDTH{1'b0}})) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module : branch_predictor_btb
// Brief  : Direct-mapped BTB with per-entry saturating direction counters,
//          combinational IF lookup, registered ID training and statistics.
// Rev    : 1.0
// ============================================================================
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int ENTRIES    = 16,
    parameter int CNT_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  startin,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [PC_WIDTH-1:0]   pred_next_pc,
    input  logic                  upd_valid,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic                  upd_taken,
    input  logic [PC_WIDTH-1:0]   upd_target,
    input  logic                  upd_mispredict,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;
    localparam logic [CNT_WIDTH-1:0] C_WEAK_NT = CNT_WIDTH'(cnt_weak_nt(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] C_WEAK_T  = CNT_WIDTH'(cnt_weak_t(CNT_WIDTH));

    logic                 r_valid  [ENTRIES];
    logic [TAG_W-1:0]     r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0]  r_target [ENTRIES];
    logic [CNT_WIDTH-1:0] w_cnt    [ENTRIES];

    logic [IDX-1:0]   w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX-1:0]   w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;

    assign w_lk_idx = IDX'(pc_index(64'(lookup_pc), IDX));
    assign w_lk_tag = TAG_W'(pc_tag(64'(lookup_pc), IDX));
    assign w_up_idx = IDX'(pc_index(64'(upd_pc), IDX));
    assign w_up_tag = TAG_W'(pc_tag(64'(upd_pc), IDX));

    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    always_comb begin
        pred_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        pred_taken   = pred_hit && w_cnt[w_lk_idx][CNT_WIDTH-1];
        pred_next_pc = lookup_pc + PC_WIDTH'(PC_INC);
        if (pred_taken) begin
            pred_next_pc = r_target[w_lk_idx];
        end
    end

    // A taken outcome either refreshes a hit or allocates over the occupant;
    // in both cases valid/tag/target end up identical.
    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic w_sel;
            assign w_sel = upd_valid && (w_up_idx == IDX'(gi));

            sat_counter #(
                .WIDTH     (CNT_WIDTH),
                .RESET_VAL (C_WEAK_NT)
            ) u_dir_cnt (
                .clk        (clk),
                .rst_n      (startin),
                .i_inc      (w_sel && w_up_hit && upd_taken),
                .i_dec      (w_sel && w_up_hit && !upd_taken),
                .i_load     (w_sel && !w_up_hit && upd_taken),
                .i_load_val (C_WEAK_T),
                .o_count    (w_cnt[gi])
            );
        end
    endgenerate

    sat_counter #(
        .WIDTH     (STAT_WIDTH),
        .RESET_VAL ('0)
    ) u_stat_branches (
        .clk        (clk),
        .rst_n      (startin),
        .i_inc      (upd_valid),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val ({STAT_WIDTH{1'b0}}),
        .o_count    (stat_branches)
    );

    sat_counter #(
        .WIDTH     (STAT_WIDTH),
        .RESET_VAL ('0)
    ) u_stat_mispredicts (
        .clk        (clk),
        .rst_n      (startin),
        .i_inc      (upd_valid && upd_mispredict),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val ({STAT_WIDTH{1'b0}}),
        .o_count    (stat_mispredicts)
    );

endmodule : branch_predictor_btb
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_predictor_btb
// Brief  : Scoreboard bench for branch_predictor_btb (32/16/2/32 plus a
//          STAT_WIDTH=3 instance for statistic saturation).
// Rev    : 1.0
// ============================================================================
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        startin = 1'b0;
    logic [31:0] lookup_pc = 32'h40;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;

    logic        pred_hit, pred_taken, pred_hit3, pred_taken3;
    logic [31:0] pred_next_pc, pred_next_pc3;
    logic [31:0] stat_branches, stat_mispredicts;
    logic [2:0]  stat_br3, stat_mp3;

    branch_predictor_btb dut (
        .clk(clk), .startin(startin), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    branch_predictor_btb #(.STAT_WIDTH(3)) dut3 (
        .clk(clk), .startin(startin), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit3), .pred_taken(pred_taken3), .pred_next_pc(pred_next_pc3),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(stat_br3), .stat_mispredicts(stat_mp3)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] npc;
        logic [31:0] br;
        logic [31:0] mp;
        logic [2:0]  br3;
        logic [2:0]  mp3;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int n_br  = 0;
    int n_mp  = 0;

    function automatic logic [2:0] sat3(input int n);
        return (n > 7) ? 3'd7 : 3'(n);
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=0x%08h expected=0x%08h", nm, fld, act, exp);
        end
    endtask

    task automatic push_exp(input string nm, input logic eh, input logic et, input logic [31:0] enpc);
        exp_t e;
        e.name = nm; e.hit = eh; e.taken = et; e.npc = enpc;
        e.br = 32'(n_br); e.mp = 32'(n_mp);
        e.br3 = sat3(n_br); e.mp3 = sat3(n_mp);
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so each expectation is due at the
    // negedge following its push.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "pred_hit",         32'(pred_hit),     32'(e.hit));
            cmp(e.name, "pred_taken",       32'(pred_taken),   32'(e.taken));
            cmp(e.name, "pred_next_pc",     pred_next_pc,      e.npc);
            cmp(e.name, "stat_branches",    stat_branches,     e.br);
            cmp(e.name, "stat_mispredicts", stat_mispredicts,  e.mp);
            cmp(e.name, "stat_br_w3",       32'(stat_br3),     32'(e.br3));
            cmp(e.name, "stat_mp_w3",       32'(stat_mp3),     32'(e.mp3));
        end
    end

    // One clock of stimulus; the optional expectation describes this cycle's
    // pre-update outputs.
    task automatic step(input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic um, input logic [31:0] lpc,
                        input logic chk, input logic eh, input logic et,
                        input logic [31:0] enpc, input string nm);
        @(posedge clk); #1;
        upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_mispredict = um; lookup_pc = lpc;
        if (chk) push_exp(nm, eh, et, enpc);
        if (uv && startin) begin
            n_br++;
            if (um) n_mp++;
        end
    endtask

    initial begin
        int guard;
        // Reset state
        step(0, 0, 0, 0, 0, 32'h40, 1, 0, 0, 32'h44, "reset");
        step(0, 0, 0, 0, 0, 32'h40, 1, 0, 0, 32'h44, "reset2");
        @(posedge clk); #1; startin = 1'b1;

        // Allocate, then hysteresis and saturation on idx 4
        step(1, 32'h10, 1, 32'h100, 0, 32'h40, 1, 0, 0, 32'h44, "alloc_cycle");
        step(1, 32'h10, 0, 32'h0,   1, 32'h10, 1, 1, 1, 32'h100, "alloc_predict");
        step(1, 32'h10, 1, 32'h104, 0, 32'h10, 1, 1, 0, 32'h14, "one_not_taken");
        step(1, 32'h10, 1, 32'h108, 0, 32'h10, 1, 1, 1, 32'h104, "retrained_taken");
        for (int i = 0; i < 4; i++)
            step(1, 32'h10, 1, 32'h100, 0, 32'h10, 0, 0, 0, 0, "");
        step(1, 32'h10, 0, 32'h0, 0, 32'h10, 1, 1, 1, 32'h100, "saturated");
        step(1, 32'h10, 0, 32'h0, 0, 32'h10, 1, 1, 1, 32'h100, "sat_minus_one");
        step(0, 0, 0, 0, 0, 32'h10, 1, 1, 0, 32'h14, "sat_minus_two");

        // Alias replacement on idx 4
        step(1, 32'h50, 1, 32'h200, 1, 32'h50, 1, 0, 0, 32'h54, "alias_alloc");
        step(0, 0, 0, 0, 0, 32'h10, 1, 0, 0, 32'h14, "alias_old_gone");
        step(0, 0, 0, 0, 0, 32'h50, 1, 1, 1, 32'h200, "alias_new");
        step(0, 0, 0, 0, 0, 32'h53, 1, 1, 1, 32'h200, "low_bits_ignored");

        // Miss not-taken leaves no entry
        step(1, 32'h20, 0, 32'h999, 0, 32'h20, 1, 0, 0, 32'h24, "miss_nt_cycle");
        step(0, 0, 0, 0, 0, 32'h20, 1, 0, 0, 32'h24, "miss_nt_after");

        // Same-cycle read/write, no bypass
        step(1, 32'h30, 1, 32'h300, 0, 32'h30, 1, 0, 0, 32'h34, "same_cycle");
        step(0, 0, 0, 0, 0, 32'h30, 1, 1, 1, 32'h300, "next_cycle");

        // Mispredict without valid is ignored; PC increment wraps
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0, 32'h0, "wrap_and_stray_misp");
        step(0, 0, 0, 0, 0, 32'h50, 1, 1, 1, 32'h200, "stats_final");

        // Asynchronous reset between edges
        @(posedge clk); #3;
        startin = 1'b0;
        lookup_pc = 32'h50;
        #1;
        n_br = 0; n_mp = 0;
        push_exp("async_reset", 0, 0, 32'h54);
        @(posedge clk); #1; startin = 1'b1;
        step(0, 0, 0, 0, 0, 32'h30, 1, 0, 0, 32'h34, "after_async_reset");

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain queue_left=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_branch_predictor_btb
`default_nettype wire

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters.
- Sits in IF next to the PC and predicts next-PC for the fetched instruction.
- Trained from ID, where branch compare and target add resolve.
- Successor to the static predict-not-taken scheme: configurable depth and counter width, tag check, allocation policy and misprediction statistics.

Parameters:
- PC_WIDTH, 32, width of PC and target addresses.
- ENTRIES, 16, number of BTB entries; power of two, >= 2.
- CNT_WIDTH, 2, direction counter width; >= 1.
- STAT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- startin  in  1  asynchronous, active-low reset.
- lookup_pc  in  PC_WIDTH  PC of the instruction in IF.
- pred_hit  out  1  valid entry with matching tag for lookup_pc.
- pred_taken  out  1  pred_hit and counter MSB = 1.
- pred_next_pc  out  PC_WIDTH  stored target if pred_taken, else lookup_pc + 4.
- upd_valid  in  1  a branch resolved in ID this cycle.
- upd_pc  in  PC_WIDTH  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_WIDTH  actual branch target.
- upd_mispredict  in  1  the IF prediction for this branch was wrong; asserted only with upd_valid.
- stat_branches  out  STAT_WIDTH  count of upd_valid cycles.
- stat_mispredicts  out  STAT_WIDTH  count of upd_valid & upd_mispredict cycles.

Behaviour:
- Address split:
  - IDX = log2(ENTRIES).
  - index = pc[IDX+1:2].
  - tag = pc[PC_WIDTH-1:IDX+2].
  - pc[1:0] is ignored.
- Per entry: valid bit, tag, target, CNT_WIDTH counter.
- Reset (startin = 0, asynchronous): all valid = 0, all counters = weakly-not-taken (MSB 0, other bits 1), targets/tags = 0, both stat counters = 0.
- Outputs after reset: pred_hit = 0, pred_taken = 0, pred_next_pc = lookup_pc + 4.
- Lookup:
  - Purely combinational from current state, zero latency.
  - pred_next_pc addition wraps modulo 2^PC_WIDTH.
- Update is registered; the new state is visible to lookup in the cycle after the upd_valid edge.
  - Same-cycle lookup and update on the same index returns the pre-update state; no bypass.
- Update rules, when upd_valid = 1 at the edge:
  - Hit (valid and tag match):
    - Counter increments if upd_taken, decrements otherwise.
    - Counter saturates at all-ones and at zero.
    - If upd_taken, target is overwritten with upd_target.
  - Miss and upd_taken: allocate.
    - valid = 1, tag = upd tag, target = upd_target.
    - Counter = weakly-taken (MSB 1, other bits 0).
    - Silently replaces any previous occupant of that index.
  - Miss and not taken: no state change.
- CNT_WIDTH = 1: weakly-taken = 1 and weakly-not-taken = 0.
- Statistics:
  - stat_branches increments on every upd_valid edge.
  - stat_mispredicts increments when upd_valid & upd_mispredict.
  - Both saturate at all-ones and do not wrap.
  - upd_mispredict without upd_valid is ignored.
- upd_valid = 0: no state change.
- Reset asserted mid-operation clears everything immediately regardless of clk; an update on the deasserting edge is lost.
- No X propagation: unused entries must not influence outputs.

Decomposition:
- Shared package holds:
  - counter encoding constants: CNT_WEAK_NT and CNT_WEAK_T as functions of CNT_WIDTH;
  - index/tag extraction functions;
  - the PC increment constant 4.
- One sub-module: sat_counter (parametrised width, inc/dec/load, saturating).
  - Reused for the direction counters and the stat counters.

Test Plan:
- Reset:
  - Stimulus: startin low with arbitrary lookup_pc = 0x0000_0040.
  - Response: pred_hit = 0, pred_taken = 0, pred_next_pc = 0x0000_0044, stats = 0.
- Allocate and predict:
  - Stimulus: upd_valid, upd_pc = 0x0000_0010, upd_taken = 1, upd_target = 0x0000_0100.
  - Response, next cycle, lookup 0x10: pred_hit = 1, pred_taken = 1, pred_next_pc = 0x100.
- Hysteresis:
  - Stimulus: from the allocated entry, one not-taken update, then lookup 0x10.
  - Response: pred_taken = 0.
  - Follow-up: two taken updates, then lookup 0x10 → pred_taken = 1.
  - Follow-up: four taken updates, then one not-taken → counter still predicts taken (saturation at 11).
- Alias replacement:
  - Stimulus: entry at 0x10, then taken update for 0x50 (same index when ENTRIES = 16, different tag), target 0x200.
  - Response: lookup 0x10 → pred_hit = 0; lookup 0x50 → pred_next_pc = 0x200.
- Miss not-taken:
  - Stimulus: update for 0x20 with upd_taken = 0.
  - Response: lookup 0x20 → pred_hit = 0.
- Same-cycle read/write:
  - Stimulus: lookup_pc = 0x30 while allocating 0x30.
  - Response: that cycle pred_hit = 0; next cycle pred_hit = 1.
- Statistics:
  - Stimulus: 5 updates, 2 with upd_mispredict; 1 upd_mispredict pulse without upd_valid.
  - Response: stat_branches = 5, stat_mispredicts = 2.
  - Follow-up: with STAT_WIDTH = 3, 9 updates → stat_branches = 7.
